// File: rtl/universal_register_pkg.sv
// Shared types for the universal register: command op-codes and FSM states.
package universal_register_pkg;

   typedef enum logic [2:0] {
      OpClr = 3'd0,
      OpLd  = 3'd1,
      OpInc = 3'd2,
      OpDec = 3'd3,
      OpShr = 3'd4,
      OpShl = 3'd5,
      OpRor = 3'd6,
      OpAsr = 3'd7
   } op_e;

   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } state_e;

   // Ops 4..7 are the multi-cycle shift/rotate family.
   function automatic logic is_shift_op(input op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/ureg_shift_step.sv
// One-bit shift/rotate step for the universal register (purely combinational).
module ureg_shift_step
   import universal_register_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] value,
   input  op_e              op,
   input  logic             fill,
   output logic [WIDTH-1:0] value_next,
   output logic             carry_out
);

   // Select the one-bit move and the bit that leaves the register.
   always_comb begin
      value_next = value;
      carry_out  = 1'b0;
      case (op)
         OpShr: begin
            value_next = {fill, value[WIDTH-1:1]};
            carry_out  = value[0];
         end
         OpShl: begin
            value_next = {value[WIDTH-2:0], fill};
            carry_out  = value[WIDTH-1];
         end
         OpRor: begin
            value_next = {value[0], value[WIDTH-1:1]};
            carry_out  = value[0];
         end
         OpAsr: begin
            value_next = {value[WIDTH-1], value[WIDTH-1:1]};
            carry_out  = value[0];
         end
         default: begin
            value_next = value;
            carry_out  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/universal_register.sv
// Universal register: clear/load/inc/dec in one cycle, shifts one bit per cycle.
// Optional build macro UNIVERSAL_REGISTER_SATURATE_EN makes INC/DEC saturate.
module universal_register
   import universal_register_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [2:0]             op,
   input  logic [DATA_WIDTH-1:0]  in,
   input  logic [SHAMT_WIDTH-1:0] shamt,
   input  logic                   fill,
   output logic [DATA_WIDTH-1:0]  out,
   output logic                   busy,
   output logic                   done,
   output logic                   zero,
   output logic                   carry
);

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  out_q, out_d;
   logic                   carry_q, carry_d;
   logic                   done_q, done_d;
   logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
   op_e                    op_q, op_d;
   logic                   fill_q, fill_d;

   op_e                    op_in;
   logic [DATA_WIDTH:0]    inc_sum, dec_diff;
   logic [DATA_WIDTH-1:0]  step_val;
   logic                   step_carry;

   assign op_in    = op_e'(op);
   // The extra top bit is the carry (INC) or borrow (DEC).
   assign inc_sum  = {1'b0, out_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
   assign dec_diff = {1'b0, out_q} - {{DATA_WIDTH{1'b0}}, 1'b1};

   ureg_shift_step #(
      .WIDTH (DATA_WIDTH)
   ) u_step (
      .value      (out_q),
      .op         (op_q),
      .fill       (fill_q),
      .value_next (step_val),
      .carry_out  (step_carry)
   );

   // Next-state: accept commands only in idle, step the shifter while busy.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      carry_d = carry_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      op_d    = op_q;
      fill_d  = fill_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (is_shift_op(op_in)) begin
                  if (shamt == '0) begin
                     done_d = 1'b1;
                  end else begin
                     op_d    = op_in;
                     fill_d  = fill;
                     cnt_d   = shamt;
                     state_d = StShift;
                  end
               end else begin
                  done_d = 1'b1;
                  unique case (op_in)
                     OpClr: begin
                        out_d   = '0;
                        carry_d = 1'b0;
                     end
                     OpLd: out_d = in;
`ifdef UNIVERSAL_REGISTER_SATURATE_EN
                     OpInc: begin
                        out_d   = inc_sum[DATA_WIDTH] ? out_q : inc_sum[DATA_WIDTH-1:0];
                        carry_d = inc_sum[DATA_WIDTH];
                     end
                     OpDec: begin
                        out_d   = dec_diff[DATA_WIDTH] ? out_q : dec_diff[DATA_WIDTH-1:0];
                        carry_d = dec_diff[DATA_WIDTH];
                     end
`else
                     OpInc: begin
                        out_d   = inc_sum[DATA_WIDTH-1:0];
                        carry_d = inc_sum[DATA_WIDTH];
                     end
                     OpDec: begin
                        out_d   = dec_diff[DATA_WIDTH-1:0];
                        carry_d = dec_diff[DATA_WIDTH];
                     end
`endif
                     default: out_d = out_q;
                  endcase
               end
            end
         end
         StShift: begin
            out_d   = step_val;
            carry_d = step_carry;
            cnt_d   = cnt_q - SHAMT_WIDTH'(1);
            if (cnt_q == SHAMT_WIDTH'(1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous active-low reset; reset also kills any pending done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         out_q   <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         op_q    <= OpClr;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         carry_q <= carry_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         fill_q  <= fill_d;
      end
   end

   assign out   = out_q;
   assign busy  = (state_q == StShift);
   assign done  = done_q;
   assign carry = carry_q;
   assign zero  = (out_q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Scoreboard bench for universal_register at DATA_WIDTH=16.
module tb_universal_register;

   localparam int DW = 16;
   localparam int SW = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [DW-1:0] din;
   logic [SW-1:0] shamt;
   logic          fill;
   logic [DW-1:0] out;
   logic          busy;
   logic          done;
   logic          zero;
   logic          carry;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string         tag;
      logic [DW-1:0] out;
      logic          carry;
      int            busy_cycles;
   } exp_t;

   exp_t exp_q[$];

   // Reference state of the register, advanced when a command is issued.
   logic [DW-1:0] m_val;
   logic          m_carry;

   universal_register #(
      .DATA_WIDTH  (DW),
      .SHAMT_WIDTH (SW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .in    (din),
      .shamt (shamt),
      .fill  (fill),
      .out   (out),
      .busy  (busy),
      .done  (done),
      .zero  (zero),
      .carry (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Whole-command reference written with word-level arithmetic.
   task automatic model(input logic [2:0] c, input logic [DW-1:0] v, input logic [SW-1:0] k,
                        input logic f, input logic [DW-1:0] cur, input logic cin,
                        output logic [DW-1:0] nv, output logic nc, output int cyc);
      int unsigned w;
      int unsigned kk;
      w   = {16'h0, cur};
      kk  = k;
      nv  = cur;
      nc  = cin;
      cyc = 0;
      case (c)
         3'd0: begin nv = '0; nc = 1'b0; end
         3'd1: nv = v;
         3'd2: begin
`ifdef UNIVERSAL_REGISTER_SATURATE_EN
            nv = (cur == 16'hFFFF) ? cur : cur + 16'd1;
`else
            nv = cur + 16'd1;
`endif
            nc = (cur == 16'hFFFF);
         end
         3'd3: begin
`ifdef UNIVERSAL_REGISTER_SATURATE_EN
            nv = (cur == 16'h0000) ? cur : cur - 16'd1;
`else
            nv = cur - 16'd1;
`endif
            nc = (cur == 16'h0000);
         end
         default: begin
            if (kk != 0) begin
               cyc = kk;
               case (c)
                  3'd4: begin
                     nv = DW'((w >> kk) | (f ? ((32'hFFFF << (DW - kk)) & 32'hFFFF) : 32'h0));
                     nc = cur[kk-1];
                  end
                  3'd5: begin
                     nv = DW'((w << kk) | (f ? ((32'h1 << kk) - 32'h1) : 32'h0));
                     nc = cur[DW-kk];
                  end
                  3'd6: begin
                     nv = DW'((w >> kk) | (w << (DW - kk)));
                     nc = cur[kk-1];
                  end
                  default: begin
                     nv = DW'($signed(cur) >>> kk);
                     nc = cur[kk-1];
                  end
               endcase
            end
         end
      endcase
   endtask

   // Issue one command: predict, push expectation, present start across one edge.
   task automatic drive(input string tag, input logic [2:0] c, input logic [DW-1:0] v,
                        input logic [SW-1:0] k, input logic f, input int busy_adjust);
      exp_t e;
      logic [DW-1:0] nv;
      logic nc;
      int cyc;
      model(c, v, k, f, m_val, m_carry, nv, nc, cyc);
      m_val   = nv;
      m_carry = nc;
      e.tag         = tag;
      e.out         = nv;
      e.carry       = nc;
      e.busy_cycles = cyc - busy_adjust;
      exp_q.push_back(e);
      op    = c;
      din   = v;
      shamt = k;
      fill  = f;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for done, then compare against the oldest expectation.
   task automatic await_done();
      exp_t e;
      int   bcnt = 0;
      int   t = 0;
      e = exp_q.pop_front();
      while (!done && t < 100) begin
         if (busy) bcnt++;
         @(posedge clk);
         #1;
         t++;
      end
      check_eq({e.tag, ".done_seen"}, 32'(done), 32'd1);
      check_eq({e.tag, ".out"}, 32'(out), 32'(e.out));
      check_eq({e.tag, ".carry"}, 32'(carry), 32'(e.carry));
      check_eq({e.tag, ".zero"}, 32'(zero), 32'(e.out == '0));
      check_eq({e.tag, ".busy_at_done"}, 32'(busy), 32'd0);
      check_eq({e.tag, ".busy_cycles"}, 32'(bcnt), 32'(e.busy_cycles));
      @(posedge clk);
      #1;
      check_eq({e.tag, ".done_width"}, 32'(done), 32'd0);
   endtask

   initial begin
      int seen_done;
      rst_n = 1'b0;
      start = 1'b0;
      op    = '0;
      din   = '0;
      shamt = '0;
      fill  = 1'b0;
      m_val   = '0;
      m_carry = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst.out", 32'(out), 32'h0);
      check_eq("rst.busy", 32'(busy), 32'd0);
      check_eq("rst.done", 32'(done), 32'd0);
      check_eq("rst.carry", 32'(carry), 32'd0);
      check_eq("rst.zero", 32'(zero), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      drive("ld8001", 3'd1, 16'h8001, 4'd0, 1'b0, 0);
      await_done();
      drive("shr3", 3'd4, 16'h0, 4'd3, 1'b1, 0);
      await_done();
      drive("ld1234", 3'd1, 16'h1234, 4'd0, 1'b0, 0);
      await_done();
      drive("ror4", 3'd6, 16'h0, 4'd4, 1'b0, 0);
      await_done();
      drive("ld8000", 3'd1, 16'h8000, 4'd0, 1'b0, 0);
      await_done();
      drive("asr15", 3'd7, 16'h0, 4'd15, 1'b0, 0);
      await_done();
      drive("inc_top", 3'd2, 16'h0, 4'd0, 1'b0, 0);
      await_done();
      drive("dec", 3'd3, 16'h0, 4'd0, 1'b0, 0);
      await_done();
      drive("clr", 3'd0, 16'h0, 4'd0, 1'b0, 0);
      await_done();
      drive("dec_zero", 3'd3, 16'h0, 4'd0, 1'b0, 0);
      await_done();
      drive("ld_ffff", 3'd1, 16'hFFFF, 4'd0, 1'b0, 0);
      await_done();
      drive("inc_carry", 3'd2, 16'h0, 4'd0, 1'b0, 0);
      await_done();
      drive("shr0", 3'd4, 16'h0, 4'd0, 1'b1, 0);
      await_done();
      drive("ld_a5c3", 3'd1, 16'hA5C3, 4'd0, 1'b0, 0);
      await_done();
      drive("shl4", 3'd5, 16'h0, 4'd4, 1'b0, 0);
      await_done();

      // A start during a shift must be ignored; one busy cycle is consumed here.
      drive("asr8_ign", 3'd7, 16'h0, 4'd8, 1'b0, 1);
      check_eq("asr8_ign.busy_pre", 32'(busy), 32'd1);
      op    = 3'd1;
      din   = 16'h0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      await_done();

      for (int i = 0; i < 8; i++) begin
         drive("rnd", 3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 0);
         await_done();
      end

      // Reset on the second shift edge of SHL 5 must abort with no done pulse.
      drive("ld_preshl", 3'd1, 16'h00FF, 4'd0, 1'b0, 0);
      await_done();
      op    = 3'd5;
      shamt = 4'd5;
      fill  = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("abort.busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_eq("abort.out", 32'(out), 32'h0);
      check_eq("abort.busy", 32'(busy), 32'd0);
      check_eq("abort.carry", 32'(carry), 32'd0);
      check_eq("abort.done", 32'(done), 32'd0);
      check_eq("abort.zero", 32'(zero), 32'd1);
      seen_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done++;
      end
      check_eq("abort.no_done", 32'(seen_done), 32'd0);
      check_eq("abort.out_hold", 32'(out), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, register width; power of two, >= 4.
REQ-002 SHALL have parameter SHAMT_WIDTH, default $clog2(DATA_WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start  input  1  command request; sampled only when idle.
REQ-006 SHALL have port op  input  3  command: 0 CLR, 1 LD, 2 INC, 3 DEC, 4 SHR, 5 SHL, 6 ROR, 7 ASR.
REQ-007 SHALL have port in  input  DATA_WIDTH  load data for LD.
REQ-008 SHALL have port shamt  input  SHAMT_WIDTH  bit count for ops 4-7.
REQ-009 SHALL have port fill  input  1  fill bit for SHR/SHL.
REQ-010 SHALL have ports out, busy, done and zero as outputs: out (DATA_WIDTH) register value; busy (1) shift in progress; done (1) one-cycle completion pulse; zero (1) high when out == 0.
REQ-011 SHALL have port carry  output  1  last carry/borrow or shifted-out bit.

Function
REQ-012 A command SHALL be accepted on a clock edge where start=1 and busy=0; start with busy=1 SHALL be ignored, with no effect.
REQ-013 CLR/LD/INC/DEC SHALL update out on the accepting edge and assert done for the following cycle only; busy SHALL stay 0.
REQ-014 CLR SHALL set out=0 and carry=0; LD SHALL set out=in, carry unchanged.
REQ-015 INC/DEC SHALL wrap modulo 2^DATA_WIDTH; carry=1 on wrap (0xFFFF->0, 0->0xFFFF), else 0.
REQ-016 Shift ops with shamt=k>0 SHALL latch op, k and fill on accept, set busy=1, then shift exactly one bit per edge for k edges.
REQ-017 On the k-th shift edge, busy SHALL go 0 and done SHALL go 1 for one cycle; out holds its final value from that edge.
REQ-018 Shift ops with shamt=0 SHALL leave out and carry unchanged and pulse done after the accepting edge; busy stays 0.
REQ-019 SHR: MSB <- latched fill; SHL: LSB <- latched fill; ROR: MSB <- old LSB; ASR: MSB <- old MSB.
REQ-020 Each shift step SHALL set carry to the bit leaving the register (LSB for SHR/ROR/ASR, MSB for SHL).
REQ-021 zero SHALL be combinational from out; all other outputs SHALL be registered.
REQ-022 FSM SHALL have two states: IDLE (busy=0) and SHIFT (busy=1); IDLE->SHIFT on accepted shift with k>0; SHIFT->IDLE after final step.

Reset
REQ-023 rst_n=0 at an edge SHALL force out=0, carry=0, busy=0, done=0, step counter=0 and state IDLE, including mid-shift; zero then reads 1.
REQ-024 A shift aborted by reset SHALL NOT produce a done pulse.

Configuration
REQ-025 With UNIVERSAL_REGISTER_SATURATE_EN defined, INC at all-ones SHALL hold all-ones and DEC at zero SHALL hold zero, each setting carry=1.
REQ-026 Without UNIVERSAL_REGISTER_SATURATE_EN, INC/DEC SHALL wrap as in REQ-015; all other behaviour is identical.

Structure
REQ-027 Package universal_register_pkg SHALL hold the op-code enum (CLR..ASR) and the FSM state enum.
REQ-028 The one-bit shift/rotate step SHALL be a combinational sub-module ureg_shift_step (inputs: value, op, fill; outputs: next value, carry-out).

Verification (DATA_WIDTH=16)
REQ-029 Reset, then LD in=0x8001 -> out=0x8001 after one edge, done high exactly one cycle, zero=0, busy never 1.
REQ-030 From 0x8001, SHR shamt=3 fill=1 -> busy 3 cycles, out=0xF000, carry=0, single done pulse on busy fall.
REQ-031 From 0x1234, ROR shamt=4 -> out=0x4123, carry=0; ASR shamt=15 on 0x8000 -> out=0xFFFF.
REQ-032 INC on 0xFFFF -> out=0x0000, carry=1, zero=1 (macro off); out=0xFFFF, carry=1 (macro on).
REQ-033 During an ASR shamt=8, start with LD in=0x0000 -> ignored; shift completes with the correct result.
REQ-034 rst_n=0 on the 2nd cycle of SHL shamt=5 -> next edge out=0, busy=0, carry=0, no done pulse.
